// File: rtl/disp_arbiter.sv
// Display arbiter: two requesters share one 3-digit 7-seg display.
// Round-robin with a minimum hold time; blanks when idle.
module disp_arbiter #(
  parameter int HOLD_CYC = 1000,
  parameter int DW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [3*DW-1:0] dat0,
  input  logic            req1,
  input  logic [3*DW-1:0] dat1,
  output logic            gnt0,
  output logic            gnt1,
  output logic [3*DW-1:0] disp_dat,
  output logic            disp_blank,
  output logic            owner
);

  localparam int HE = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int CW = $clog2(HE + 1);
  localparam logic [CW-1:0] LOAD = CW'(HE - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            rr_q, rr_d;
  logic            own_q, own_d;
  logic            g0_q, g0_d;
  logic            g1_q, g1_d;
  logic            blk_q, blk_d;
  logic [3*DW-1:0] dat_q, dat_d;

  logic            req_own, req_oth, win;
  logic [3*DW-1:0] dat_own, dat_oth;

  // Route owner/other views and pick the idle-state winner.
  always_comb begin
    req_own = own_q ? req1 : req0;
    req_oth = own_q ? req0 : req1;
    dat_own = own_q ? dat1 : dat0;
    dat_oth = own_q ? dat0 : dat1;
    win     = (req0 & req1) ? ~rr_q : req1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    own_d   = own_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    blk_d   = blk_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = OWN;
          own_d   = win;
          rr_d    = win;
          hold_d  = LOAD;
          g0_d    = ~win;
          g1_d    = win;
          blk_d   = 1'b0;
          dat_d   = win ? dat1 : dat0;
        end else begin
          g0_d  = 1'b0;
          g1_d  = 1'b0;
          blk_d = 1'b1;
          dat_d = '0;
        end
      end
      OWN: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
          if (req_own) dat_d = dat_own;
        end else if (req_oth) begin
          own_d  = ~own_q;
          rr_d   = ~own_q;
          hold_d = LOAD;
          g0_d   = own_q;
          g1_d   = ~own_q;
          dat_d  = dat_oth;
        end else if (req_own) begin
          dat_d = dat_own;
        end else begin
          state_d = IDLE;
          g0_d    = 1'b0;
          g1_d    = 1'b0;
          blk_d   = 1'b1;
          dat_d   = '0;
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rr_q    <= 1'b1;
      own_q   <= 1'b0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      blk_q   <= 1'b1;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      blk_q   <= blk_d;
      dat_q   <= dat_d;
    end
  end

  assign gnt0       = g0_q;
  assign gnt1       = g1_q;
  assign disp_dat   = dat_q;
  assign disp_blank = blk_q;
  assign owner      = own_q;

endmodule
